bsg_then_ready_link_stripe_masked: RTL
======================================

// Module: bsg_then_ready_link_stripe_masked
// PURPOSE
// Parametrised successor to the 2-link static round-robin concentrator between the channel
// tunnel and the DDR io links. Stripes one core-side link across num_links_p physical links
// in strict rotation. Reassembles in the same rotation on receive. Adds a runtime link-enable
// mask so a board can run degraded with any subset of io links enabled.
// Both chips must load identical masks while quiescent.
// PARAMETERS
// width_p        32               flit width, all links
// num_links_p    2                physical links, 1..8
// reset_mask_p   {num_links_p{1}} enable mask loaded by reset; must be nonzero
// PORTS
// clk_i          in   1              core clock
// reset_i        in   1              asynchronous, active-high reset
// mask_load_i    in   1              load mask_i this cycle
// mask_i         in   num_links_p    new link-enable mask
// mask_o         out  num_links_p    current mask register
// mask_err_o     out  1              one-cycle pulse: all-zero mask rejected
// single_v_i     in   1              core->links valid
// single_data_i  in   width_p        core->links flit
// single_ready_and_o out 1           core->links ready (v&ready = accept)
// single_v_o     out  1              links->core valid
// single_data_o  out  width_p        links->core flit
// single_yumi_i  in   1              links->core consume
// links_v_o      out  num_links_p    per-link tx valid
// links_data_o   out  num_links_p*width_p  per-link tx flit (broadcast of single_data_i)
// links_ready_and_i in num_links_p   per-link tx ready
// links_v_i      in   num_links_p    per-link rx valid
// links_data_i   in   num_links_p*width_p  per-link rx flit
// links_yumi_o   out  num_links_p    per-link rx consume
// BEHAVIOUR
// - State: mask_r, tx_ptr_r, rx_ptr_r. ptr width = max(1,$clog2(num_links_p)).
//   Async reset: mask_r=reset_mask_p; both ptrs = lowest set bit of reset_mask_p.
// - Outputs while reset_i=1: links_v_o=0, single_ready_and_o=0, single_v_o=0,
//   links_yumi_o=0, mask_err_o=0.
// - TX, combinational:
//   links_v_o[i] = single_v_i & (i==tx_ptr_r); single_ready_and_o = links_ready_and_i[tx_ptr_r].
//   Accept (v & ready): tx_ptr_r <= next enabled link after tx_ptr_r, circular, wrapping
//   num_links_p-1 -> 0. Exactly one flit per enabled link per rotation.
// - RX, combinational: single_v_o = links_v_i[rx_ptr_r]; single_data_o = links_data_i[rx_ptr_r];
//   links_yumi_o[i] = single_yumi_i & (i==rx_ptr_r). On yumi, rx_ptr_r advances like tx_ptr_r.
//   Valid on non-pointed links is held off; a disabled link is never read.
// - Latency: zero-cycle pass-through both directions. No storage. Full throughput of
//   1 flit/cycle per direction.
// - Single enabled link: the pointer stays fixed; behaves as a wire to that link.
// - Mask load, mask_i != 0: mask_r <= mask_i. Both ptrs <= lowest set bit of mask_i.
//   A TX/RX handshake in the same cycle completes on the old ptr; the load overrides
//   that cycle's advance.
// - Mask load, mask_i == 0: mask_r and ptrs unchanged; mask_err_o=1 for that cycle.
// - Loading while flits are in flight is legal for this block but corrupts ordering at
//   the far end. Software drains before loading; the block does not check.
// - Ptr next-enabled search: rotate mask right by ptr+1, priority-encode, add back mod
//   num_links_p. Result is never a disabled link.
// TESTING
// - n=2, mask 11: send 0x10..0x17 with all ready -> links_v_o alternates 01,10;
//   link0 gets 10,12,14,16. Loopback rx returns 10..17 in order.
// - n=4, mask 1011: 6 flits -> link order 0,1,3,0,1,3. Link2 never valid and never yumi'd.
// - n=4, mask 1111, links_ready_and_i[2]=0 for 5 cycles -> stall on link2 only;
//   single_ready_and_o=0 and tx_ptr_r holds at 2. After ready returns, the rotation resumes at 2.
// - Load mask 0000 -> mask_err_o pulses 1 cycle; mask_o and rotation unchanged.
//   Load 0100 in the same cycle as a tx accept on link1 -> flit goes on link1;
//   next flit goes on link2.
// - Assert reset_i mid-burst between clock edges -> outputs 0 immediately; after release,
//   ptrs at lowest bit of reset_mask_p and mask_o = reset_mask_p.
// - Random traffic with random ready/valid, n=3, mask 101, looped back -> rx stream equals
//   tx stream, and no flit is observed on link1.

Source files
------------

// File: rtl/bsg_then_ready_link_stripe_masked.sv
`default_nettype none
// ============================================================================
// Module   : bsg_then_ready_link_stripe_masked
// Brief    : Stripes one core-side ready/valid link across num_links_p
//            physical links in strict rotation over the enabled links.
//            Reassembles received flits in the same rotation. A runtime
//            enable mask selects which links take part in the rotation.
//            Data passes straight through with no storage and no added latency.
// Revision : 1.0  initial release
// ============================================================================
module bsg_then_ready_link_stripe_masked #(
   parameter int                      width_p      = 32,
   parameter int                      num_links_p  = 2,
   parameter logic [num_links_p-1:0]  reset_mask_p = {num_links_p{1'b1}}
) (
   input  logic                             clk_i,
   input  logic                             reset_i,

   input  logic                             mask_load_i,
   input  logic [num_links_p-1:0]           mask_i,
   output logic [num_links_p-1:0]           mask_o,
   output logic                             mask_err_o,

   input  logic                             single_v_i,
   input  logic [width_p-1:0]               single_data_i,
   output logic                             single_ready_and_o,

   output logic                             single_v_o,
   output logic [width_p-1:0]               single_data_o,
   input  logic                             single_yumi_i,

   output logic [num_links_p-1:0]           links_v_o,
   output logic [num_links_p*width_p-1:0]   links_data_o,
   input  logic [num_links_p-1:0]           links_ready_and_i,

   input  logic [num_links_p-1:0]           links_v_i,
   input  logic [num_links_p*width_p-1:0]   links_data_i,
   output logic [num_links_p-1:0]           links_yumi_o
);

   localparam int c_ptr_w = (num_links_p > 1) ? $clog2(num_links_p) : 1;

   typedef logic [c_ptr_w-1:0]     ptr_t;
   typedef logic [num_links_p-1:0] mask_t;

   // Index of the lowest set bit of m (0 if m is empty).
   function automatic ptr_t f_lowest(input mask_t m);
      ptr_t  res;
      mask_t tmp;
      res = '0;
      for (int i = num_links_p - 1; i >= 0; i--) begin
         tmp = m >> i;
         if (tmp[0]) res = ptr_t'(i);
      end
      return res;
   endfunction

   // Next enabled link strictly after p, wrapping circularly. Scanning
   // offsets from farthest to nearest lets the nearest enabled link win;
   // offset num_links_p is p itself, so a lone enabled link maps to itself.
   function automatic ptr_t f_next(input mask_t m, input ptr_t p);
      ptr_t  res;
      mask_t tmp;
      int    idx;
      res = p;
      for (int k = num_links_p; k >= 1; k--) begin
         idx = int'(p) + k;
         if (idx >= num_links_p) idx = idx - num_links_p;
         tmp = m >> idx;
         if (tmp[0]) res = ptr_t'(idx);
      end
      return res;
   endfunction

   mask_t              r_mask;
   ptr_t               r_tx_ptr;
   ptr_t               r_rx_ptr;

   logic               w_tx_ready;
   logic               w_rx_v;
   logic [width_p-1:0] w_rx_data;
   logic               w_tx_accept;
   logic               w_rx_yumi;
   logic               w_load_ok;
   logic               w_load_zero;

   // Select the pointed link's ready (tx side) and valid/data (rx side).
   always_comb begin
      w_tx_ready = 1'b0;
      w_rx_v     = 1'b0;
      w_rx_data  = '0;
      for (int i = 0; i < num_links_p; i++) begin
         if (r_tx_ptr == ptr_t'(i)) begin
            w_tx_ready = links_ready_and_i[i];
         end
         if (r_rx_ptr == ptr_t'(i)) begin
            w_rx_v    = links_v_i[i];
            w_rx_data = links_data_i[i*width_p +: width_p];
         end
      end
   end

   assign w_tx_accept = single_v_i & w_tx_ready;
   assign w_rx_yumi   = single_yumi_i;
   assign w_load_ok   = mask_load_i & (mask_i != '0);
   assign w_load_zero = mask_load_i & (mask_i == '0);

   assign single_ready_and_o = w_tx_ready & ~reset_i;
   assign single_v_o         = w_rx_v & ~reset_i;
   assign single_data_o      = w_rx_data;
   assign mask_o             = r_mask;
   assign mask_err_o         = w_load_zero & ~reset_i;

   // Per-link strobes: only the pointed link ever sees valid or yumi.
   for (genvar g = 0; g < num_links_p; g++) begin : g_link
      assign links_v_o[g]    = single_v_i & (r_tx_ptr == ptr_t'(g)) & ~reset_i;
      assign links_yumi_o[g] = single_yumi_i & (r_rx_ptr == ptr_t'(g)) & ~reset_i;
      assign links_data_o[g*width_p +: width_p] = single_data_i;
   end

   // Mask register and rotation pointers; a valid mask load overrides any
   // advance in the same cycle, while the handshake itself used the old pointer.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_mask   <= reset_mask_p;
         r_tx_ptr <= f_lowest(reset_mask_p);
         r_rx_ptr <= f_lowest(reset_mask_p);
      end else if (w_load_ok) begin
         r_mask   <= mask_i;
         r_tx_ptr <= f_lowest(mask_i);
         r_rx_ptr <= f_lowest(mask_i);
      end else begin
         if (w_tx_accept) r_tx_ptr <= f_next(r_mask, r_tx_ptr);
         if (w_rx_yumi)   r_rx_ptr <= f_next(r_mask, r_rx_ptr);
      end
   end

endmodule
`default_nettype wire
